sr_latch_driver: RTL

Clocked command front-end that drives the S/R inputs of the cross-coupled NOR SR latch. It converts one-word set/clear/toggle commands into width-controlled, mutually exclusive S or R pulses, inserts a dead time after each pulse, and can confirm the latch output through a synchronized Q feedback path. It is the synchronous controller that sits between the lab's clocked logic and the asynchronous latch.

---
 rtl/sr_latch_driver.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// Clocked set/clear/toggle front-end for a cross-coupled NOR SR latch.
// Define SR_DRV_VERIFY_EN to build the Q-feedback CHECK phase, its synchronizer and err reporting.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int DEAD_W  = 1,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       q_fb,
    output logic       s_out,
    output logic       r_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       state_q
);

    localparam int CNT_MAX_PD = (PULSE_W > DEAD_W) ? PULSE_W : DEAD_W;
    localparam int CNT_MAX    = (CNT_MAX_PD > TIMEOUT) ? CNT_MAX_PD : TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'((DEAD_W > 0) ? DEAD_W - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_DEAD,
        ST_CHECK
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             nop_q, nop_d;
    logic             latch_q, latch_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             endShaping;

`ifdef SR_DRV_VERIFY_EN
    logic             err_q, err_d;
    logic             sync1_q, sync2_q;
`else
    logic             unused_q_fb;
`endif

    assign accept = cmd_valid & ready_q;

    // The PULSE phase spends one extra cycle so the registered S/R drive
    // rises the edge after accept and stays high for exactly PULSE_W cycles.
    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        done_d     = nop_q;
        nop_d      = 1'b0;
        latch_d    = latch_q;
        endShaping = 1'b0;
`ifdef SR_DRV_VERIFY_EN
        err_d      = 1'b0;
`endif

        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    case (cmd_op)
                        OP_SET: begin
                            target_d = 1'b1;
                            fsm_d    = ST_PULSE;
                        end
                        OP_CLEAR: begin
                            target_d = 1'b0;
                            fsm_d    = ST_PULSE;
                        end
                        OP_TOGGLE: begin
                            target_d = ~latch_q;
                            fsm_d    = ST_PULSE;
                        end
                        default: begin
                            nop_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if (DEAD_W > 0) begin
                        fsm_d = ST_DEAD;
                    end else begin
                        endShaping = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    s_d   = target_q;
                    r_d   = ~target_q;
                end
            end

            ST_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    cnt_d      = '0;
                    endShaping = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef SR_DRV_VERIFY_EN
            ST_CHECK: begin
                if (sync2_q == target_q) begin
                    fsm_d   = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    latch_d = target_q;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fsm_d   = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    latch_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif

            default: begin
                fsm_d = ST_IDLE;
                cnt_d = '0;
            end
        endcase

        if (endShaping) begin
`ifdef SR_DRV_VERIFY_EN
            fsm_d   = ST_CHECK;
`else
            fsm_d   = ST_IDLE;
            done_d  = 1'b1;
            latch_d = target_q;
`endif
        end

        ready_d = (fsm_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    // State and every output are flops so the latch never sees a combinational glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            done_q   <= 1'b0;
            nop_q    <= 1'b0;
            latch_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            nop_q    <= nop_d;
            latch_q  <= latch_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

`ifdef SR_DRV_VERIFY_EN
    // q_fb comes straight from the asynchronous latch, so it is double-flopped before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= q_fb;
            sync2_q <= sync1_q;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
`endif

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;
    assign state_q   = latch_q;

endmodule
